// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word reads over a req/ack
// handshake and buffers returned words in a small FIFO for the core.
module mips_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc
);

    localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] RESET_ADDR = RESET_PC & 32'hFFFF_FFFC;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    logic [1:0]    state_reg, state_next;
    logic [31:0]   addr_reg, addr_next;
    logic [31:0]   fpc_reg, fpc_next;
    logic [AW:0]   count_reg, count_next;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [31:0]   mem_pc_reg   [DEPTH];
    logic [31:0]   mem_data_reg [DEPTH];

    logic          push;
    logic          pop;
    logic          room;
    logic [AW+1:0] level;
    logic [31:0]   target;

    assign target      = redirect_pc & 32'hFFFF_FFFC;
    assign imem_req    = (state_reg != IDLE);
    assign imem_addr   = addr_reg;
    assign instr_valid = (count_reg != '0);
    assign instruction = instr_valid ? mem_data_reg[rd_ptr_reg] : 32'd0;
    assign instr_pc    = instr_valid ? mem_pc_reg[rd_ptr_reg] : 32'd0;

    assign push  = (state_reg == WAIT) && imem_ack && !redirect;
    assign pop   = instr_valid && instr_ready && !redirect;
    assign level = {1'b0, count_reg} + (AW+2)'(push) - (AW+2)'(pop);
    assign room  = level < (AW+2)'(DEPTH);

    always_comb begin
        state_next  = state_reg;
        addr_next   = addr_reg;
        fpc_next    = fpc_reg;
        count_next  = level[AW:0];
        wr_ptr_next = wr_ptr_reg + AW'(push);
        rd_ptr_next = rd_ptr_reg + AW'(pop);
        if (push) begin
            fpc_next = addr_reg + 32'd4;
        end
        if (redirect) begin
            count_next  = '0;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            fpc_next    = target;
            // An unacked request cannot be withdrawn; let it finish and discard it.
            if (state_reg != IDLE && !imem_ack) begin
                state_next = DROP;
            end else begin
                state_next = WAIT;
                addr_next  = target;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (room) begin
                        state_next = WAIT;
                        addr_next  = fpc_reg;
                    end
                end
                WAIT: begin
                    if (imem_ack) begin
                        if (room) begin
                            addr_next = addr_reg + 32'd4;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            addr_reg   <= RESET_ADDR;
            fpc_reg    <= RESET_ADDR;
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            state_reg  <= state_next;
            addr_reg   <= addr_next;
            fpc_reg    <= fpc_next;
            count_reg  <= count_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    mem_pc_reg[gi]   <= 32'd0;
                    mem_data_reg[gi] <= 32'd0;
                end else if (push && wr_ptr_reg == AW'(gi)) begin
                    mem_pc_reg[gi]   <= addr_reg;
                    mem_data_reg[gi] <= imem_rdata;
                end
            end
        end
    endgenerate

endmodule

// File: doc/mips_fetch_unit.md
# mips_fetch_unit

Instruction fetch stage for the MIPS single-cycle core. It sits directly upstream of the core's `instruction` input. It owns the fetch PC and issues word reads to instruction memory over a request/acknowledge handshake that tolerates variable latency. Returned words are buffered in a small FIFO and presented to the core with a valid/ready handshake. Branch and jump redirects flush the buffer and drop any in-flight response.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset; bits [1:0] are ignored and treated as 0.
- `DEPTH`, default 2: FIFO entries; a power of two in 2..8.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `imem_req` out 1: read request; registered output.
- `imem_addr` out 32: word-aligned read address; registered; stable while `imem_req` is high.
- `imem_ack` in 1: memory has returned `imem_rdata` for the current request; sampled only while `imem_req` is high.
- `imem_rdata` in 32: read data, valid when `imem_ack` is high.
- `redirect` in 1: one-cycle pulse requesting a fetch from a new address.
- `redirect_pc` in 32: new fetch address; bits [1:0] are forced to 0.
- `instr_valid` out 1: the FIFO head is valid.
- `instr_ready` in 1: the core accepts the head this cycle.
- `instruction` out 32: FIFO head instruction word.
- `instr_pc` out 32: address the head word was fetched from.

## Operation
- State machine has three states:
  - IDLE: no request outstanding.
  - WAIT: request outstanding; its response will be kept.
  - DROP: request outstanding; its response will be discarded.
- `imem_req` = (state != IDLE).
- FIFO `count` ranges 0..DEPTH. `instr_valid` = (count != 0). `instruction`/`instr_pc` show the head entry and are 0 when the FIFO is empty.
- push = (state == WAIT) & `imem_ack` & !`redirect`. Writes {`imem_addr`, `imem_rdata`} at the tail.
- pop = `instr_valid` & `instr_ready` & !`redirect`.
- room = (count + push − pop) < DEPTH.
- Fetch pointer `fpc` holds the next address to request. On push, `fpc` ← `imem_addr` + 4, wrapping modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- Transitions without `redirect`:
  - IDLE → WAIT when room; `imem_addr` ← `fpc`.
  - WAIT with ack → WAIT when room, with `imem_addr` ← `imem_addr` + 4 (back-to-back); otherwise → IDLE.
  - WAIT without ack → WAIT; address held.
  - DROP with ack → IDLE; data discarded.
  - DROP without ack → DROP.
- On `redirect`:
  - FIFO flushes (count ← 0) and `fpc` ← {`redirect_pc`[31:2], 2'b00}.
  - If a request is outstanding and `imem_ack` is low, state → DROP. The request stays asserted with its address unchanged until acked, because the handshake may not be abandoned.
  - Otherwise (IDLE, or ack arriving in this cycle), state → WAIT with `imem_addr` ← aligned `redirect_pc`. Any ack data in this cycle is discarded.
- `redirect` in DROP with no ack: state stays DROP and `fpc` takes the newest target.
- `redirect` with a simultaneous pop: the redirect wins; the head is flushed and not counted as consumed.
- Full FIFO: no request is issued. Pushes never overflow, because room gates issue.

## Timing
- Reset (asynchronous, `rst` low):
  - state = IDLE.
  - `imem_req` = 0, `imem_addr` = RESET_PC aligned, `fpc` = RESET_PC aligned.
  - count = 0, `instr_valid` = 0, `instruction` = 0, `instr_pc` = 0.
  - FIFO storage cleared.
- First rising edge after `rst` goes high: `imem_req` goes to 1 with `imem_addr` = RESET_PC.
- Memory latency is arbitrary, and zero-wait is legal: `imem_ack` may be high in the first cycle `imem_req` is high.
- Ack edge → `instr_valid` high in the following cycle (1-cycle latency).
- Zero-wait memory with `instr_ready` held high sustains one instruction per cycle.
- Redirect edge → new-target request visible the next cycle. If in DROP, the new-target request follows one cycle after the dropped ack.
- Reset asserted mid-transaction returns everything to reset values immediately. Memory must tolerate the abandoned request.

## Test plan
- Reset + zero-wait memory returning `addr` as data, `instr_ready`=1: addresses 0,4,8,… requested back-to-back; `instruction`/`instr_pc` = 0,4,8 on consecutive cycles after a 2-cycle startup.
- Memory with 3-cycle ack latency: `imem_addr` held stable for 3 cycles per request; one instruction every 3 cycles; `instr_valid` pulses 1 cycle after each ack.
- `instr_ready`=0, DEPTH=2: after 2 pushes count=2 and `imem_req` drops to 0. Raising `instr_ready` pops 0 then 4, and fetch of 8 resumes.
- Redirect to 32'h0000_0103 while a request is pending with no ack: state DROP, stale response discarded. Next request is to 32'h0000_0100; first delivered `instr_pc` = 32'h100.
- Redirect in the same cycle as ack and pop with the FIFO holding 1 entry: FIFO empty the next cycle and ack data not delivered; `imem_addr` = new target.
- `rst` pulled low mid-WAIT with the FIFO holding 1 entry: outputs return to reset values asynchronously. Fetch restarts at RESET_PC after release.
